// File: rtl/lcd_spi_stream_if.sv
// Valid/ready word stream from the pixel/command sequencer into lcd_spi_stream.
interface lcd_spi_stream_if #(
  parameter int unsigned DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_dc;
  logic              in_wide;
  logic              in_delay;

  modport master (output in_valid, in_data, in_dc, in_wide, in_delay, input in_ready);
  modport slave  (input in_valid, in_data, in_dc, in_wide, in_delay, output in_ready);
endinterface

// File: rtl/lcd_spi_stream.sv
// SPI write engine for ST7735-class panels: word FIFO, panel reset sequence, mode-0 serialiser.
// Optional delay tokens are compiled in with `define LCD_SPI_DELAY_EN.
module lcd_spi_stream #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned RST_LOW_CYC  = 100,
  parameter int unsigned RST_WAIT_CYC = 1200,
  parameter int unsigned DELAY_UNIT   = 1000
) (
  input  logic             clk,
  input  logic             resetn,
  lcd_spi_stream_if.slave  s_in,
  output logic             panel_rdy,
  output logic             busy,
  output logic             lcd_rst_n,
  output logic             spi_cs,
  output logic             spi_dc,
  output logic             spi_clk,
  output logic             spi_mosi
);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_A   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int unsigned CNT_B   = (DELAY_UNIT > CLK_DIV) ? DELAY_UNIT : CLK_DIV;
  localparam int unsigned CNT_MAX = (CNT_A > CNT_B) ? CNT_A : CNT_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(DATA_W);
`ifdef LCD_SPI_DELAY_EN
  localparam int unsigned EW      = DATA_W + 3;
`else
  localparam int unsigned EW      = DATA_W + 2;
`endif

  typedef enum logic [2:0] {
    ST_RST_LOW, ST_RST_WAIT, ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_DELAY
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bits;
  logic [DATA_W-1:0] r_shift;
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic              r_in_ready, r_panel_rdy, r_busy, r_lcd_rst_n;
  logic              r_spi_cs, r_spi_dc, r_spi_clk, r_spi_mosi;

  logic [AW:0]       w_fill, w_fill_nxt;
  logic [EW-1:0]     w_head, w_entry;
  logic [DATA_W-1:0] w_head_al;
  logic              w_push, w_pop, w_empty, w_cnt_zero, w_last_fall;
  logic              w_head_dly, w_dly_exit, w_active_nxt;

`ifdef LCD_SPI_DELAY_EN
  logic [DATA_W-1:0] r_dly;
  assign w_entry    = {s_in.in_delay, s_in.in_wide, s_in.in_dc, s_in.in_data};
  assign w_head_dly = w_head[DATA_W+2];
  assign w_dly_exit = (r_dly == '0);
`else
  logic w_unused_delay;
  assign w_unused_delay = s_in.in_delay;
  assign w_entry    = {s_in.in_wide, s_in.in_dc, s_in.in_data};
  assign w_head_dly = 1'b0;
  assign w_dly_exit = 1'b1;
`endif

  assign w_fill     = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (w_fill == '0);
  assign w_push     = s_in.in_valid && r_in_ready;
  assign w_fill_nxt = w_fill + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_cnt_zero = (r_cnt == '0);
  // Narrow words are left-aligned so the shifter always emits from the top bit.
  assign w_head_al  = w_head[DATA_W+1] ? w_head[DATA_W-1:0]
                                       : (DATA_W'(w_head[7:0]) << (DATA_W - 8));
  assign w_last_fall = (r_state == ST_SHIFT) && r_spi_clk && w_cnt_zero && (r_bits == '0);
  // Delay tokens are never chained into a burst; they go through HOLD/IDLE first.
  assign w_pop = !w_empty && (((r_state == ST_IDLE) && w_cnt_zero) || (w_last_fall && !w_head_dly));
  assign w_active_nxt = (r_state == ST_SETUP) || (r_state == ST_SHIFT) ||
                        ((r_state == ST_HOLD) && !w_cnt_zero) ||
                        ((r_state == ST_DELAY) && !w_dly_exit) || w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_RST_LOW;
      r_cnt       <= CNT_W'(RST_LOW_CYC - 1);
      r_bits      <= '0;
      r_shift     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_in_ready  <= 1'b0;
      r_panel_rdy <= 1'b0;
      r_busy      <= 1'b0;
      r_lcd_rst_n <= 1'b0;
      r_spi_cs    <= 1'b1;
      r_spi_dc    <= 1'b0;
      r_spi_clk   <= 1'b0;
      r_spi_mosi  <= 1'b0;
`ifdef LCD_SPI_DELAY_EN
      r_dly       <= '0;
`endif
    end else begin
      r_in_ready <= (w_fill_nxt != (AW+1)'(FIFO_DEPTH));
      r_busy     <= (w_fill_nxt != '0) || w_active_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);

      case (r_state)
        ST_RST_LOW: begin
          if (w_cnt_zero) begin
            r_lcd_rst_n <= 1'b1;
            r_state     <= ST_RST_WAIT;
            r_cnt       <= CNT_W'(RST_WAIT_CYC - 1);
          end else r_cnt <= r_cnt - CNT_W'(1);
        end
        ST_RST_WAIT: begin
          if (w_cnt_zero) begin
            r_panel_rdy <= 1'b1;
            r_state     <= ST_IDLE;
          end else r_cnt <= r_cnt - CNT_W'(1);
        end
        ST_IDLE: begin
          if (!w_cnt_zero) r_cnt <= r_cnt - CNT_W'(1);
        end
        ST_SETUP: begin
          if (w_cnt_zero) begin
            r_spi_clk <= 1'b1;
            r_state   <= ST_SHIFT;
            r_cnt     <= CNT_W'(CLK_DIV - 1);
          end else r_cnt <= r_cnt - CNT_W'(1);
        end
        ST_SHIFT: begin
          if (!w_cnt_zero) r_cnt <= r_cnt - CNT_W'(1);
          else if (!r_spi_clk) begin
            r_spi_clk <= 1'b1;
            r_cnt     <= CNT_W'(CLK_DIV - 1);
          end else begin
            // Falling edge: advance MOSI, or finish the word.
            r_spi_clk <= 1'b0;
            r_cnt     <= CNT_W'(CLK_DIV - 1);
            if (r_bits == '0) r_state <= ST_HOLD;
            else begin
              r_spi_mosi <= r_shift[DATA_W-1];
              r_shift    <= r_shift << 1;
              r_bits     <= r_bits - BIT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (w_cnt_zero) begin
            r_spi_cs <= 1'b1;
            r_state  <= ST_IDLE;
            r_cnt    <= CNT_W'(CLK_DIV - 1);
          end else r_cnt <= r_cnt - CNT_W'(1);
        end
`ifdef LCD_SPI_DELAY_EN
        ST_DELAY: begin
          if (w_dly_exit) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_W'(CLK_DIV - 1);
          end else if (w_cnt_zero) begin
            r_dly <= r_dly - DATA_W'(1);
            r_cnt <= CNT_W'(DELAY_UNIT - 1);
          end else r_cnt <= r_cnt - CNT_W'(1);
        end
`endif
        default: r_state <= ST_IDLE;
      endcase

      // A pop overrides the case transition: start the next word (or delay).
      if (w_pop) begin
        if (w_head_dly) begin
`ifdef LCD_SPI_DELAY_EN
          r_state <= ST_DELAY;
          r_dly   <= w_head[DATA_W-1:0];
          r_cnt   <= CNT_W'(DELAY_UNIT - 1);
`endif
        end else begin
          r_state    <= ST_SETUP;
          r_cnt      <= CNT_W'(CLK_DIV - 1);
          r_spi_cs   <= 1'b0;
          r_spi_dc   <= w_head[DATA_W];
          r_spi_mosi <= w_head_al[DATA_W-1];
          r_shift    <= w_head_al << 1;
          r_bits     <= w_head[DATA_W+1] ? BIT_W'(DATA_W - 1) : BIT_W'(7);
        end
      end
    end
  end

  assign s_in.in_ready = r_in_ready;
  assign panel_rdy     = r_panel_rdy;
  assign busy          = r_busy;
  assign lcd_rst_n     = r_lcd_rst_n;
  assign spi_cs        = r_spi_cs;
  assign spi_dc        = r_spi_dc;
  assign spi_clk       = r_spi_clk;
  assign spi_mosi      = r_spi_mosi;
endmodule
